// File: rtl/operand_entry.sv
// rtl/operand_entry.sv - two-digit operand entry: button sync, debounce, edge detect, entry FSM
// Optional feature macro: BCD_CHECK_EN (reject digits above 9 and flag entry_err).
module operand_entry #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] sw,
    input  logic       enter_btn,
    input  logic       clear_btn,
    output logic [3:0] nib_lo,
    output logic [3:0] nib_hi,
    output logic       operand_valid,
    output logic       load_pulse,
    output logic [1:0] entry_state,
    output logic       entry_err
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        EMPTY     = 2'd0,
        HIGH_HELD = 2'd1,
        FULL      = 2'd2,
        UNUSED    = 2'd3
    } state_t;

    // Bit 0 carries the enter button, bit 1 the clear button.
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    stable;
    logic [1:0]    stable_d;
    logic [CW-1:0] cnt [2];

    logic   enter_evt;
    logic   clear_evt;
    logic   digit_ok;
    state_t state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= '0;
            sync2    <= '0;
            stable   <= '0;
            stable_d <= '0;
            cnt[0]   <= '0;
            cnt[1]   <= '0;
        end else begin
            sync1    <= {clear_btn, enter_btn};
            sync2    <= sync1;
            stable_d <= stable;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] != stable[i]) begin
                    if (cnt[i] == CNT_MAX) begin
                        stable[i] <= sync2[i];
                        cnt[i]    <= '0;
                    end else begin
                        cnt[i] <= cnt[i] + CW'(1);
                    end
                end else begin
                    cnt[i] <= '0;
                end
            end
        end
    end

    assign enter_evt = stable[0] & ~stable_d[0];
    assign clear_evt = stable[1] & ~stable_d[1];

`ifdef BCD_CHECK_EN
    assign digit_ok = (sw <= 4'd9);
`else
    assign digit_ok = 1'b1;
`endif

    // Clear outranks enter; a rejected digit leaves the operand untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= EMPTY;
            nib_hi        <= '0;
            nib_lo        <= '0;
            operand_valid <= 1'b0;
            load_pulse    <= 1'b0;
        end else begin
            load_pulse <= 1'b0;
            if (clear_evt || state == UNUSED) begin
                state         <= EMPTY;
                nib_hi        <= '0;
                nib_lo        <= '0;
                operand_valid <= 1'b0;
            end else if (enter_evt && digit_ok) begin
                case (state)
                    HIGH_HELD: begin
                        nib_lo        <= sw;
                        operand_valid <= 1'b1;
                        load_pulse    <= 1'b1;
                        state         <= FULL;
                    end
                    default: begin
                        nib_hi        <= sw;
                        nib_lo        <= '0;
                        operand_valid <= 1'b0;
                        state         <= HIGH_HELD;
                    end
                endcase
            end
        end
    end

`ifdef BCD_CHECK_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (clear_evt || state == UNUSED) begin
            err_q <= 1'b0;
        end else if (enter_evt) begin
            err_q <= ~digit_ok;
        end
    end

    assign entry_err = err_q;
`else
    assign entry_err = 1'b0;
`endif

    assign entry_state = state;

endmodule

// File: tb/tb_operand_entry.sv
// tb/tb_operand_entry.sv - directed self-checking bench for operand_entry
module tb_operand_entry;

    logic       clk;
    logic       rst_n;
    logic [3:0] sw;
    logic       enter_btn;
    logic       clear_btn;
    logic [3:0] nib_lo;
    logic [3:0] nib_hi;
    logic       operand_valid;
    logic       load_pulse;
    logic [1:0] entry_state;
    logic       entry_err;

    int n_cmp;
    int n_bad;
    int lp_cnt;
    int lp_base;
    int lat;

    operand_entry #(.DEBOUNCE_CYCLES(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sw            (sw),
        .enter_btn     (enter_btn),
        .clear_btn     (clear_btn),
        .nib_lo        (nib_lo),
        .nib_hi        (nib_hi),
        .operand_valid (operand_valid),
        .load_pulse    (load_pulse),
        .entry_state   (entry_state),
        .entry_err     (entry_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && load_pulse) lp_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Hold enter for 40 cycles, reporting the negedge index at which entry_state moves.
    task automatic press_timed(input logic [3:0] v, output int latency);
        logic [1:0] prev;
        bit found;
        prev = entry_state;
        found = 0;
        latency = -1;
        @(posedge clk); #1;
        sw = v;
        enter_btn = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (!found && entry_state != prev) begin
                found = 1;
                latency = n;
            end
        end
        @(posedge clk); #1;
        enter_btn = 1'b0;
        settle(25);
    endtask

    task automatic press(input logic [3:0] v);
        @(posedge clk); #1;
        sw = v;
        enter_btn = 1'b1;
        settle(30);
        enter_btn = 1'b0;
        settle(25);
    endtask

    task automatic bounce(input int pulses);
        for (int p = 0; p < pulses; p++) begin
            enter_btn = 1'b1;
            settle(5);
            enter_btn = 1'b0;
            settle(5);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        lp_cnt = 0;
        rst_n = 1'b0;
        sw = 4'h0;
        enter_btn = 1'b0;
        clear_btn = 1'b0;

        settle(3);
        chk("rst_nib_lo", nib_lo, 0);
        chk("rst_nib_hi", nib_hi, 0);
        chk("rst_valid", operand_valid, 0);
        chk("rst_load", load_pulse, 0);
        chk("rst_state", entry_state, 0);
        chk("rst_err", entry_err, 0);
        rst_n = 1'b1;
        settle(50);
        chk("idle_state", entry_state, 0);
        chk("idle_nibs", {nib_hi, nib_lo}, 8'h00);
        chk("idle_load_cnt", lp_cnt, 0);

        // Normal two-digit entry, high digit first
        lp_base = lp_cnt;
        press_timed(4'h3, lat);
        chk("lat_first_ok", (lat >= 18 && lat <= 20), 1);
        chk("first_state", entry_state, 1);
        chk("first_nibs", {nib_hi, nib_lo}, 8'h30);
        chk("first_valid", operand_valid, 0);
        press_timed(4'h7, lat);
        chk("lat_second_ok", (lat >= 18 && lat <= 20), 1);
        chk("op37_nibs", {nib_hi, nib_lo}, 8'h37);
        chk("op37_valid", operand_valid, 1);
        chk("op37_state", entry_state, 2);
        chk("op37_loads", lp_cnt - lp_base, 1);

        // New operand from FULL
        lp_base = lp_cnt;
        press(4'hA);
        chk("ovw_nibs", {nib_hi, nib_lo}, 8'hA0);
        chk("ovw_valid", operand_valid, 0);
        chk("ovw_state", entry_state, 1);
        press(4'h1);
        chk("opA1_nibs", {nib_hi, nib_lo}, 8'hA1);
        chk("opA1_valid", operand_valid, 1);
        chk("opA1_state", entry_state, 2);
        chk("opA1_loads", lp_cnt - lp_base, 1);

        // Short glitches never reach the FSM
        lp_base = lp_cnt;
        sw = 4'h5;
        bounce(6);
        settle(25);
        chk("glitch_state", entry_state, 2);
        chk("glitch_nibs", {nib_hi, nib_lo}, 8'hA1);
        chk("glitch_loads", lp_cnt - lp_base, 0);
        bounce(10);
        enter_btn = 1'b1;
        settle(30);
        enter_btn = 1'b0;
        settle(25);
        chk("bounce_state", entry_state, 1);
        chk("bounce_nibs", {nib_hi, nib_lo}, 8'h50);
        chk("bounce_loads", lp_cnt - lp_base, 0);

        // Simultaneous clear and enter from HIGH_HELD
        lp_base = lp_cnt;
        sw = 4'h9;
        enter_btn = 1'b1;
        clear_btn = 1'b1;
        settle(30);
        enter_btn = 1'b0;
        clear_btn = 1'b0;
        settle(25);
        chk("clr_state", entry_state, 0);
        chk("clr_nibs", {nib_hi, nib_lo}, 8'h00);
        chk("clr_valid", operand_valid, 0);
        chk("clr_loads", lp_cnt - lp_base, 0);

`ifdef BCD_CHECK_EN
        press(4'hC);
        chk("bcd_rej_err", entry_err, 1);
        chk("bcd_rej_state", entry_state, 0);
        chk("bcd_rej_nibs", {nib_hi, nib_lo}, 8'h00);
        press(4'h5);
        chk("bcd_ok_err", entry_err, 0);
        chk("bcd_ok_hi", nib_hi, 4'h5);
        chk("bcd_ok_state", entry_state, 1);
`else
        press(4'hC);
        chk("hex_err", entry_err, 0);
        chk("hex_hi", nib_hi, 4'hC);
        chk("hex_state", entry_state, 1);
`endif

        // Mid-cycle async reset with enter held through deassertion
        sw = 4'h2;
        enter_btn = 1'b1;
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_state", entry_state, 0);
        chk("arst_nibs", {nib_hi, nib_lo}, 8'h00);
        chk("arst_valid", operand_valid, 0);
        chk("arst_err", entry_err, 0);
        settle(4);
        rst_n = 1'b1;
        lp_base = lp_cnt;
        settle(40);
        enter_btn = 1'b0;
        settle(25);
        chk("held_state", entry_state, 1);
        chk("held_nibs", {nib_hi, nib_lo}, 8'h20);
        chk("held_loads", lp_cnt - lp_base, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/operand_entry.md
Name: operand_entry

Overview:
- Upstream stage of the nibble combiner in the calculator datapath.
- Collects two 4-bit digits, entered one at a time from switches with a push-button, and holds them as a low/high nibble pair.
- The nibble pair drives the combiner's 4-bit a (low) and b (high) inputs, which form the 8-bit operand.
- Contains button synchronisation, debouncing, edge detection and the entry-sequencing FSM.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive cycles a synchronised button level must differ from its stable level before it is accepted. Legal range 2..2^20. Counter width is derived with $clog2.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- sw  input  4  digit value from switches
- enter_btn  input  1  raw, asynchronous, bouncy "enter digit" button, active-high
- clear_btn  input  1  raw, asynchronous, bouncy "clear" button, active-high
- nib_lo  output  4  low nibble, to combiner input a
- nib_hi  output  4  high nibble, to combiner input b
- operand_valid  output  1  high while a complete two-digit operand is held
- load_pulse  output  1  one-cycle strobe when the second digit completes an operand
- entry_state  output  2  FSM state: 0=EMPTY, 1=HIGH_HELD, 2=FULL
- entry_err  output  1  rejected-digit flag; tied 0 unless BCD_CHECK_EN is defined

Behaviour:
- Reset (async assert, sync deassert by design): all outputs 0, FSM EMPTY, synchronisers/stable levels/counters 0.
- Synchroniser: each button passes through a 2-flop synchroniser.
- Debounce, per button:
  - counter increments each cycle the synchronised level != stable level;
  - counter clears to 0 when the levels match;
  - when the counter equals DEBOUNCE_CYCLES-1 and the levels still mismatch, stable takes the synchronised level and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES is ignored.
- Edge detect: enter_evt / clear_evt = stable & ~stable_delayed, exactly one cycle per accepted press. Release generates nothing.
- Digit order: the first digit entered is the high nibble and the second is the low nibble (most-significant digit typed first).
- sw is sampled in the cycle the event is high.
- FSM, on enter_evt:
  - EMPTY: nib_hi <= sw, nib_lo <= 0 -> HIGH_HELD.
  - HIGH_HELD: nib_lo <= sw, operand_valid <= 1, load_pulse <= 1 for one cycle -> FULL.
  - FULL: starts a new operand. nib_hi <= sw, nib_lo <= 0, operand_valid <= 0 -> HIGH_HELD.
  - No enter_evt: hold all registers; load_pulse is 0.
- clear_evt: nib_hi, nib_lo, operand_valid, entry_err <= 0 -> EMPTY, from any state.
- clear_evt and enter_evt in the same cycle: clear wins and the digit is discarded.
- All outputs are registered. nib_lo, nib_hi and operand_valid change in the same cycle as load_pulse.
- Latency: load_pulse rises one clock after the enter_evt cycle.
- Reset mid-debounce or mid-entry: everything returns to reset values. A button held through reset deassertion is accepted as a new press after DEBOUNCE_CYCLES.
- Unused state encoding 3: next state EMPTY with registers cleared.

Optional Feature:
- Macro: BCD_CHECK_EN.
- Defined:
  - an enter_evt with sw > 9 is rejected: state, nib_hi, nib_lo, operand_valid unchanged, no load_pulse;
  - entry_err <= 1, held until the next accepted digit or clear_evt, either of which sets it to 0.
- Undefined: all 16 sw values accepted; entry_err is constant 0.

Test Plan:
- Reset: rst_n=0 asserted mid-cycle -> all outputs 0 immediately. Release, idle 50 cycles -> outputs unchanged.
- Normal entry, DEBOUNCE_CYCLES=16:
  - sw=4'h3, press enter 40 cycles, release; sw=4'h7, press/release -> nib_hi=3, nib_lo=7, operand_valid=1, exactly one load_pulse, entry_state=2. Combined operand 8'h37.
  - Each press is accepted between 18 and 20 cycles after the raw rise.
- Bounce rejection: enter toggling with 5-cycle high/low pulses for 60 cycles, then stable low -> no state change. Then 10 bounces followed by 30 cycles stable high -> exactly one digit accepted.
- Overwrite from FULL:
  - holding operand 0x37, sw=4'hA, press -> nib_hi=A, nib_lo=0, operand_valid=0, entry_state=1;
  - then sw=4'h1, press -> 0xA1 valid with one load_pulse.
- Clear priority: enter and clear raw rising in the same cycle with identical waveforms, from HIGH_HELD -> EMPTY, nibbles 0, no load_pulse.
- BCD_CHECK_EN defined: sw=4'hC, press in EMPTY -> entry_err=1, entry_state=0. Then sw=4'h5, press -> entry_err=0, nib_hi=5.
